clk_div_bank: RTL and testbench



---
 rtl/clk_div_pkg.sv | 19 +
 rtl/clk_div_ch.sv | 97 +++++++++
 rtl/clk_div_bank.sv | 33 +++
 tb/tb_clk_div_bank.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared definitions for the multi-channel clock divider bank.
// Holds the channel state encoding and the ratios used by the UART
// TX/RX clock derivation.
package clk_div_pkg;

    localparam int DEFAULT_RATIO_W = 8;

    typedef enum logic {
        DIV_IDLE = 1'b0,
        DIV_RUN  = 1'b1
    } div_state_e;

    // UART_CLK / 32 gives the 115.2 kHz TX clock.
    localparam int TX_RATIO            = 32;
    localparam int RX_RATIO_PRESCALE16 = 2;
    // The hardware clamps ratios below 2, so this value divides by 2, not 1.
    localparam int RX_RATIO_PRESCALE32 = 1;

endpackage

// File: rtl/clk_div_ch.sv
// Single divider channel: period counter, latched ratio and registered
// output clock, with an optional start-of-period tick.
// Optional feature macro: CLK_DIV_BANK_TICK_EN (tick register present when defined).
//
//   state    | meaning
//   ---------+-----------------------------------------------------
//   DIV_IDLE | output held low, counter cleared, waiting for enable
//   DIV_RUN  | dividing; ratio and enable resampled at period end
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int RATIO_W = DEFAULT_RATIO_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [RATIO_W-1:0] ratio,
    output logic               div_clk,
    output logic               tick
);

    div_state_e         state;
    logic [RATIO_W-1:0] cnt;
    logic [RATIO_W-1:0] r_act;
    logic [RATIO_W-1:0] ratio_eff;
    logic [RATIO_W-1:0] cnt_next;
    logic [RATIO_W:0]   half;
    logic               last;

    // Ratios of 0 and 1 cannot be produced from a registered output, so
    // they run as divide-by-2; high phase is ceil(r_act/2) cycles.
    always_comb begin
        ratio_eff = (ratio < RATIO_W'(2)) ? RATIO_W'(2) : ratio;
        cnt_next  = cnt + 1'b1;
        half      = ({1'b0, r_act} + 1'b1) >> 1;
        last      = (cnt == (r_act - 1'b1));
    end

    // Channel state machine: ratio and enable only take effect at the
    // period boundary so every started period completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= DIV_IDLE;
            cnt     <= '0;
            r_act   <= RATIO_W'(2);
            div_clk <= 1'b0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    cnt <= '0;
                    if (en) begin
                        state   <= DIV_RUN;
                        r_act   <= ratio_eff;
                        div_clk <= 1'b1;
                    end else begin
                        div_clk <= 1'b0;
                    end
                end
                DIV_RUN: begin
                    if (!last) begin
                        cnt     <= cnt_next;
                        div_clk <= ({1'b0, cnt_next} < half);
                    end else if (en) begin
                        r_act   <= ratio_eff;
                        cnt     <= '0;
                        div_clk <= 1'b1;
                    end else begin
                        state   <= DIV_IDLE;
                        cnt     <= '0;
                        div_clk <= 1'b0;
                    end
                end
            endcase
        end
    end

`ifdef CLK_DIV_BANK_TICK_EN
    logic start;

    // A period starts on the same edge where div_clk rises.
    always_comb begin
        start = en && ((state == DIV_IDLE) || last);
    end

    // Registered tick, aligned with the rising edge of div_clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick <= 1'b0;
        end else begin
            tick <= start;
        end
    end
`else
    assign tick = 1'b0;
`endif

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH independent programmable integer clock dividers running
// in the reference clock domain (typically UART_CLK).
// Optional feature macro: CLK_DIV_BANK_TICK_EN (drives o_tick when defined,
// otherwise o_tick is constant 0).
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int RATIO_W = DEFAULT_RATIO_W
) (
    input  logic                      i_ref_clk,
    input  logic                      i_rst,
    input  logic [NUM_CH-1:0]         i_en,
    input  logic [NUM_CH*RATIO_W-1:0] i_ratio,
    output logic [NUM_CH-1:0]         o_div_clk,
    output logic [NUM_CH-1:0]         o_tick
);

    // One fully independent divider per channel.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        clk_div_ch #(
            .RATIO_W (RATIO_W)
        ) u_ch (
            .clk     (i_ref_clk),
            .rst     (i_rst),
            .en      (i_en[k]),
            .ratio   (i_ratio[k*RATIO_W +: RATIO_W]),
            .div_clk (o_div_clk[k]),
            .tick    (o_tick[k])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank (2 channels, 8-bit ratios).
module tb_clk_div_bank;
    import clk_div_pkg::*;

    localparam int NUM_CH  = 2;
    localparam int RATIO_W = 8;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_CH-1:0]         en;
    logic [RATIO_W-1:0]        r0;
    logic [RATIO_W-1:0]        r1;
    logic [NUM_CH*RATIO_W-1:0] ratio;
    logic [NUM_CH-1:0]         div_clk;
    logic [NUM_CH-1:0]         tick;

    int errors = 0;
    int checks = 0;

    assign ratio = {r1, r0};

    always #5 clk = ~clk;

    clk_div_bank #(
        .NUM_CH  (NUM_CH),
        .RATIO_W (RATIO_W)
    ) dut (
        .i_ref_clk (clk),
        .i_rst     (rst),
        .i_en      (en),
        .i_ratio   (ratio),
        .o_div_clk (div_clk),
        .o_tick    (tick)
    );

    typedef struct {
        logic [1:0] en;
        logic [7:0] r0;
        logic [7:0] r1;
        logic [1:0] exp_clk;
        logic [1:0] exp_tick;
    } vec_t;

    vec_t tbl [19];

    function automatic logic [1:0] tk(input logic [1:0] t);
`ifdef CLK_DIV_BANK_TICK_EN
        return t;
`else
        return 2'b00;
`endif
    endfunction

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic [1:0] ec, input logic [1:0] et);
        check({name, ".clk"}, div_clk, ec);
        check({name, ".tick"}, tick, tk(et));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 2'b00;
        r0  = 8'd0;
        r1  = 8'd0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_out("reset", 2'b00, 2'b00);
    endtask

    initial begin
        // ch0 ratio 4, ch1 ratio 5; at row 10 ch0 is at cnt=1 and its
        // ratio changes to 6, which takes effect after row 12.
        tbl[0]  = '{2'b11, 8'd4, 8'd5, 2'b11, 2'b11};
        tbl[1]  = '{2'b11, 8'd4, 8'd5, 2'b11, 2'b00};
        tbl[2]  = '{2'b11, 8'd4, 8'd5, 2'b10, 2'b00};
        tbl[3]  = '{2'b11, 8'd4, 8'd5, 2'b00, 2'b00};
        tbl[4]  = '{2'b11, 8'd4, 8'd5, 2'b01, 2'b01};
        tbl[5]  = '{2'b11, 8'd4, 8'd5, 2'b11, 2'b10};
        tbl[6]  = '{2'b11, 8'd4, 8'd5, 2'b10, 2'b00};
        tbl[7]  = '{2'b11, 8'd4, 8'd5, 2'b10, 2'b00};
        tbl[8]  = '{2'b11, 8'd4, 8'd5, 2'b01, 2'b01};
        tbl[9]  = '{2'b11, 8'd4, 8'd5, 2'b01, 2'b00};
        tbl[10] = '{2'b11, 8'd6, 8'd5, 2'b10, 2'b10};
        tbl[11] = '{2'b11, 8'd6, 8'd5, 2'b10, 2'b00};
        tbl[12] = '{2'b11, 8'd6, 8'd5, 2'b11, 2'b01};
        tbl[13] = '{2'b11, 8'd6, 8'd5, 2'b01, 2'b00};
        tbl[14] = '{2'b11, 8'd6, 8'd5, 2'b01, 2'b00};
        tbl[15] = '{2'b11, 8'd6, 8'd5, 2'b10, 2'b10};
        tbl[16] = '{2'b11, 8'd6, 8'd5, 2'b10, 2'b00};
        tbl[17] = '{2'b11, 8'd6, 8'd5, 2'b10, 2'b00};
        tbl[18] = '{2'b11, 8'd6, 8'd5, 2'b01, 2'b01};

        do_reset();
        for (int i = 0; i < 19; i++) begin
            en = tbl[i].en;
            r0 = tbl[i].r0;
            r1 = tbl[i].r1;
            step();
            check_out($sformatf("tbl[%0d]", i), tbl[i].exp_clk, tbl[i].exp_tick);
        end

        // TX ratio on ch0 and divide-by-2 on ch1 together.
        do_reset();
        en = 2'b11;
        r0 = 8'(TX_RATIO);
        r1 = 8'(RX_RATIO_PRESCALE16);
        for (int i = 0; i < 64; i++) begin
            step();
            check_out($sformatf("tx_rx[%0d]", i),
                      {((i % 2) == 0), ((i % 32) < 16)},
                      {((i % 2) == 0), ((i % 32) == 0)});
        end

        // Drop enable at cnt=1 with ratio 8, plus a ratio change that must be discarded.
        do_reset();
        en = 2'b01;
        r0 = 8'd8;
        step(); check_out("drop.e1", 2'b01, 2'b01);
        step(); check_out("drop.e2", 2'b01, 2'b00);
        en = 2'b00;
        r0 = 8'd5;
        for (int i = 3; i <= 8; i++) begin
            step();
            check_out($sformatf("drop.e%0d", i), {1'b0, (i < 5)}, 2'b00);
        end
        for (int i = 9; i <= 18; i++) begin
            step();
            check_out($sformatf("drop.idle%0d", i), 2'b00, 2'b00);
        end
        en = 2'b01;
        r0 = 8'd3;
        step(); check_out("reen.0", 2'b01, 2'b01);
        step(); check_out("reen.1", 2'b01, 2'b00);
        step(); check_out("reen.2", 2'b00, 2'b00);
        step(); check_out("reen.3", 2'b01, 2'b01);
        step(); check_out("reen.4", 2'b01, 2'b00);
        step(); check_out("reen.5", 2'b00, 2'b00);

        // Ratios 0 and 1 both run as divide-by-2.
        do_reset();
        en = 2'b11;
        r0 = 8'd0;
        r1 = 8'(RX_RATIO_PRESCALE32);
        for (int i = 0; i < 8; i++) begin
            step();
            check_out($sformatf("clamp[%0d]", i),
                      ((i % 2) == 0) ? 2'b11 : 2'b00,
                      ((i % 2) == 0) ? 2'b11 : 2'b00);
        end

        // Asynchronous reset while the output is high and the tick is asserted.
        do_reset();
        en = 2'b01;
        r0 = 8'd8;
        step(); check_out("arst.pre", 2'b01, 2'b01);
        #2;
        rst = 1'b1;
        #1;
        check_out("arst.now", 2'b00, 2'b00);
        @(posedge clk);
        #2;
        rst = 1'b0;
        step(); check_out("arst.resume0", 2'b01, 2'b01);
        step(); check_out("arst.resume1", 2'b01, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
